// File: rtl/spi_hedef_birimi.sv
// SPI target: oversamples sck/csn/mosi on clk_i, delivers received bytes on a
// valid/ready stream and shifts bytes from a 1-entry holding register onto miso.
//
//   state | meaning
//   BOSTA | idle, waiting for a synchronised csn fall; sck edges ignored
//   AKTAR | frame active, miso driven, sample/shift on sck edges
module spi_hedef_birimi #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       cfg_cpol_i,
  input  logic       cfg_cpha_i,
  input  logic       cfg_msb_first_i,
  input  logic       sck_i,
  input  logic       csn_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  input  logic [7:0] tx_veri_i,
  input  logic       tx_gecerli_i,
  output logic       tx_hazir_o,
  output logic [7:0] rx_veri_o,
  output logic       rx_gecerli_o,
  input  logic       rx_hazir_i,
  output logic       rx_tasma_o,
  output logic       tx_eksik_o,
  output logic       aktif_o
);

  typedef enum logic {BOSTA, AKTAR} durum_t;

  durum_t durum_q, durum_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  logic       sck_dly_q, sck_dly_d;
  logic       csn_dly_q, csn_dly_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic       msb_q, msb_d;
  logic [2:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] rx_veri_q, rx_veri_d;
  logic       rx_gecerli_q, rx_gecerli_d;
  logic       rx_tasma_q, rx_tasma_d;
  logic       tx_eksik_q, tx_eksik_d;

  logic       sck_s, csn_s, mosi_s;
  logic       sck_rise, sck_fall, lead_ev, trail_ev;
  logic       sample_ev, shift_ev;
  logic       csn_fall, csn_rise;
  logic       tx_load;
  logic [7:0] rx_byte;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise  = sck_s & ~sck_dly_q;
  assign sck_fall  = ~sck_s & sck_dly_q;
  assign csn_fall  = ~csn_s & csn_dly_q;
  assign csn_rise  = csn_s & ~csn_dly_q;
  assign lead_ev   = cpol_q ? sck_fall : sck_rise;
  assign trail_ev  = cpol_q ? sck_rise : sck_fall;
  assign sample_ev = cpha_q ? trail_ev : lead_ev;
  assign shift_ev  = cpha_q ? lead_ev : trail_ev;

  always_comb begin
    sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], sck_i};
    csn_sync_d   = {csn_sync_q[SYNC_STAGES-2:0], csn_i};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    // Tracking sck every cycle means the copy already equals sck at frame start.
    sck_dly_d    = sck_s;
    csn_dly_d    = csn_s;
    durum_d      = durum_q;
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    msb_d        = msb_q;
    tx_cnt_d     = tx_cnt_q;
    rx_cnt_d     = rx_cnt_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    rx_veri_d    = rx_veri_q;
    rx_gecerli_d = rx_gecerli_q;
    rx_tasma_d   = 1'b0;
    tx_eksik_d   = 1'b0;
    tx_load      = 1'b0;
    rx_byte      = rx_sr_q;

    if (rx_gecerli_q && rx_hazir_i) rx_gecerli_d = 1'b0;

    unique case (durum_q)
      BOSTA: begin
        if (csn_fall) begin
          cpol_d   = cfg_cpol_i;
          cpha_d   = cfg_cpha_i;
          msb_d    = cfg_msb_first_i;
          tx_cnt_d = 3'd0;
          rx_cnt_d = 3'd0;
          rx_sr_d  = 8'h00;
          tx_load  = ~cfg_cpha_i;
          durum_d  = AKTAR;
        end
      end
      AKTAR: begin
        if (csn_rise) begin
          durum_d  = BOSTA;
          tx_cnt_d = 3'd0;
          rx_cnt_d = 3'd0;
          rx_sr_d  = 8'h00;
        end else begin
          if (shift_ev) begin
            tx_cnt_d = tx_cnt_q + 3'd1;
            if (tx_cnt_q == (cpha_q ? 3'd0 : 3'd7)) tx_load = 1'b1;
            else tx_sr_d = msb_q ? {tx_sr_q[6:0], 1'b0} : {1'b0, tx_sr_q[7:1]};
          end
          if (sample_ev) begin
            rx_cnt_d = rx_cnt_q + 3'd1;
            rx_byte  = msb_q ? {rx_sr_q[6:0], mosi_s} : {mosi_s, rx_sr_q[7:1]};
            rx_sr_d  = rx_byte;
            if (rx_cnt_q == 3'd7) begin
              if (!rx_gecerli_q || rx_hazir_i) begin
                rx_veri_d    = rx_byte;
                rx_gecerli_d = 1'b1;
              end else begin
                rx_tasma_d = 1'b1;
              end
            end
          end
        end
      end
      default: durum_d = BOSTA;
    endcase

    // Load sees the old holding content; a same-cycle write refills it.
    if (tx_load) begin
      if (hold_full_q) begin
        tx_sr_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sr_d    = 8'h00;
        tx_eksik_d = 1'b1;
      end
    end
    if (tx_gecerli_i && !hold_full_q) begin
      hold_d      = tx_veri_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q      <= BOSTA;
      sck_sync_q   <= '0;
      csn_sync_q   <= '1;
      mosi_sync_q  <= '0;
      sck_dly_q    <= 1'b0;
      csn_dly_q    <= 1'b1;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      msb_q        <= 1'b0;
      tx_cnt_q     <= 3'd0;
      rx_cnt_q     <= 3'd0;
      tx_sr_q      <= 8'h00;
      rx_sr_q      <= 8'h00;
      hold_q       <= 8'h00;
      hold_full_q  <= 1'b0;
      rx_veri_q    <= 8'h00;
      rx_gecerli_q <= 1'b0;
      rx_tasma_q   <= 1'b0;
      tx_eksik_q   <= 1'b0;
    end else begin
      durum_q      <= durum_d;
      sck_sync_q   <= sck_sync_d;
      csn_sync_q   <= csn_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sck_dly_q    <= sck_dly_d;
      csn_dly_q    <= csn_dly_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      msb_q        <= msb_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      rx_veri_q    <= rx_veri_d;
      rx_gecerli_q <= rx_gecerli_d;
      rx_tasma_q   <= rx_tasma_d;
      tx_eksik_q   <= tx_eksik_d;
    end
  end

  assign miso_o       = (durum_q == AKTAR) & (msb_q ? tx_sr_q[7] : tx_sr_q[0]);
  assign miso_oe_o    = (durum_q == AKTAR);
  assign aktif_o      = (durum_q == AKTAR);
  assign tx_hazir_o   = ~hold_full_q;
  assign rx_veri_o    = rx_veri_q;
  assign rx_gecerli_o = rx_gecerli_q;
  assign rx_tasma_o   = rx_tasma_q;
  assign tx_eksik_o   = tx_eksik_q;

endmodule

// File: tb/tb_spi_hedef_birimi.sv
// Bench for spi_hedef_birimi: a bit-level SPI master drives frames while a
// byte-level model predicts what each side should see.
module tb_spi_hedef_birimi;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       cfg_cpol_i, cfg_cpha_i, cfg_msb_first_i;
  logic       sck_i, csn_i, mosi_i;
  logic       miso_o, miso_oe_o;
  logic [7:0] tx_veri_i;
  logic       tx_gecerli_i;
  logic       tx_hazir_o;
  logic [7:0] rx_veri_o;
  logic       rx_gecerli_o;
  logic       rx_hazir_i;
  logic       rx_tasma_o, tx_eksik_o, aktif_o;

  spi_hedef_birimi #(.SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cfg_cpol_i(cfg_cpol_i), .cfg_cpha_i(cfg_cpha_i), .cfg_msb_first_i(cfg_msb_first_i),
    .sck_i(sck_i), .csn_i(csn_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o),
    .tx_veri_i(tx_veri_i), .tx_gecerli_i(tx_gecerli_i), .tx_hazir_o(tx_hazir_o),
    .rx_veri_o(rx_veri_o), .rx_gecerli_o(rx_gecerli_o), .rx_hazir_i(rx_hazir_i),
    .rx_tasma_o(rx_tasma_o), .tx_eksik_o(tx_eksik_o), .aktif_o(aktif_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  logic [7:0] feed_mem [0:255];
  int         feed_wr = 0;
  int         feed_rd = 0;
  logic [7:0] rx_log [$];
  int         eksik_cnt = 0;
  int         tasma_cnt = 0;
  logic [7:0] m_tx [0:7];
  logic [7:0] m_rx [0:7];
  logic [7:0] f_tx [0:7];

  // Producer: writes queued bytes into the holding register whenever it is empty.
  initial begin
    tx_gecerli_i = 1'b0;
    tx_veri_i    = 8'h00;
    forever begin
      @(negedge clk_i);
      if (rstn_i === 1'b1 && feed_rd < feed_wr && tx_hazir_o === 1'b1) begin
        tx_veri_i    = feed_mem[feed_rd];
        tx_gecerli_i = 1'b1;
        @(posedge clk_i);
        #1;
        tx_gecerli_i = 1'b0;
        feed_rd++;
      end
    end
  end

  always @(negedge clk_i) begin
    if (rstn_i === 1'b1) begin
      if (rx_gecerli_o && rx_hazir_i) rx_log.push_back(rx_veri_o);
      if (tx_eksik_o) eksik_cnt++;
      if (rx_tasma_o) tasma_cnt++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue nfed bytes from f_tx; the first one must reach the holding register before the frame.
  task automatic push_feed(input int nfed);
    int budget;
    if (nfed == 0) return;
    feed_mem[feed_wr[7:0]] = f_tx[0];
    feed_wr++;
    budget = 0;
    while (feed_rd != feed_wr && budget < 20) begin
      tick(1);
      budget++;
    end
    chk("preload_written", 32'(feed_rd == feed_wr), 32'd1);
    for (int k = 1; k < nfed; k++) begin
      feed_mem[feed_wr[7:0]] = f_tx[k];
      feed_wr++;
    end
  endtask

  // Bit-level master. nbits_abort>0 raises csn after that many bits.
  task automatic spi_frame(input bit cpol, input bit cpha, input bit msb, input int n,
                           input int nbits_abort, input int h);
    int nbits, idx, pos;
    nbits = (nbits_abort > 0) ? nbits_abort : n * 8;
    for (int k = 0; k < 8; k++) m_rx[k] = 8'h00;
    cfg_cpol_i = cpol; cfg_cpha_i = cpha; cfg_msb_first_i = msb;
    sck_i = cpol;
    tick(h);
    mosi_i = m_tx[0][msb ? 7 : 0];
    csn_i = 1'b0;
    tick(h);
    // Configuration must be ignored once the frame is running.
    cfg_cpol_i = 1'($urandom_range(1, 0));
    cfg_cpha_i = 1'($urandom_range(1, 0));
    cfg_msb_first_i = 1'($urandom_range(1, 0));
    for (int i = 0; i < nbits; i++) begin
      idx = i / 8;
      pos = msb ? 7 - (i % 8) : (i % 8);
      if (!cpha) begin
        mosi_i = m_tx[idx][pos];
        m_rx[idx] = msb ? {m_rx[idx][6:0], miso_o} : {miso_o, m_rx[idx][7:1]};
        sck_i = ~cpol;
        tick(h);
        sck_i = cpol;
        tick(h);
      end else begin
        sck_i = ~cpol;
        mosi_i = m_tx[idx][pos];
        tick(h);
        m_rx[idx] = msb ? {m_rx[idx][6:0], miso_o} : {miso_o, m_rx[idx][7:1]};
        sck_i = cpol;
        tick(h);
      end
      if (i == 3) chk("aktif_oe_mid_frame", {30'd0, aktif_o, miso_oe_o}, 32'd3);
    end
    csn_i = 1'b1;
    tick(h + 2);
    chk("aktif_after_frame", 32'(aktif_o), 32'd0);
  endtask

  // Full frame with rx_hazir_i=1; expectations come from the byte-level model.
  task automatic checked_frame(input bit cpol, input bit cpha, input bit msb,
                               input int n, input int nfed, input string tag);
    int e0, t0, rb, loads, h;
    loads = cpha ? n : n + 1;
    push_feed(nfed);
    e0 = eksik_cnt; t0 = tasma_cnt; rb = rx_log.size();
    h = $urandom_range(6, 4);
    spi_frame(cpol, cpha, msb, n, 0, h);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_miso_b%0d", tag, k), 32'(m_rx[k]), 32'((k < nfed) ? f_tx[k] : 8'h00));
      chk($sformatf("%s_mosi_b%0d", tag, k),
          (rb + k < rx_log.size()) ? 32'(rx_log[rb + k]) : 32'hxxxx_xxxx, 32'(m_tx[k]));
    end
    chk({tag, "_rx_count"}, 32'(rx_log.size() - rb), 32'(n));
    chk({tag, "_eksik"}, 32'(eksik_cnt - e0), 32'(loads - nfed));
    chk({tag, "_tasma"}, 32'(tasma_cnt - t0), 32'd0);
  endtask

  initial begin
    int e0, t0, rb, n, loads, nfed;
    bit cp, ch, mb;
    rstn_i = 1'b0;
    cfg_cpol_i = 1'b0; cfg_cpha_i = 1'b0; cfg_msb_first_i = 1'b1;
    sck_i = 1'b0; csn_i = 1'b1; mosi_i = 1'b0;
    rx_hazir_i = 1'b0;
    tick(5);
    rstn_i = 1'b1;
    tick(3);

    chk("rst_miso", 32'(miso_o), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe_o), 32'd0);
    chk("rst_aktif", 32'(aktif_o), 32'd0);
    chk("rst_rx_veri", 32'(rx_veri_o), 32'h00);
    chk("rst_rx_gecerli", 32'(rx_gecerli_o), 32'd0);
    chk("rst_pulses", {30'd0, rx_tasma_o, tx_eksik_o}, 32'd0);
    chk("rst_tx_hazir", 32'(tx_hazir_o), 32'd1);

    // Mode 0 basic exchange; a spare byte covers the load on the final trailing edge.
    f_tx[0] = 8'hA5; f_tx[1] = 8'hFF;
    m_tx[0] = 8'h3C;
    push_feed(2);
    e0 = eksik_cnt; t0 = tasma_cnt;
    spi_frame(1'b0, 1'b0, 1'b1, 1, 0, 4);
    chk("m0_miso", 32'(m_rx[0]), 32'hA5);
    chk("m0_rx_veri", 32'(rx_veri_o), 32'h3C);
    chk("m0_rx_gecerli", 32'(rx_gecerli_o), 32'd1);
    chk("m0_no_pulses", 32'((eksik_cnt - e0) + (tasma_cnt - t0)), 32'd0);
    rx_hazir_i = 1'b1;
    tick(2);
    chk("m0_drained", 32'(rx_gecerli_o), 32'd0);

    // Modes 1..3 in both bit orders, fixed TX pattern, random MOSI.
    f_tx[0] = 8'h01; f_tx[1] = 8'h02; f_tx[2] = 8'h04; f_tx[3] = 8'h80;
    for (int md = 1; md < 4; md++) begin
      for (int o = 0; o < 2; o++) begin
        for (int k = 0; k < 4; k++) m_tx[k] = 8'($urandom);
        checked_frame(md[1], md[0], o[0], 4, 4, $sformatf("mode%0d_msb%0d", md, o));
      end
    end

    // Underrun: nothing written, two loads in a CPHA=1 two-byte frame.
    for (int k = 0; k < 2; k++) m_tx[k] = 8'($urandom);
    checked_frame(1'b0, 1'b1, 1'b1, 2, 0, "underrun");

    // Overflow: consumer stalled across two bytes.
    rx_hazir_i = 1'b0;
    m_tx[0] = 8'h11; m_tx[1] = 8'h22;
    t0 = tasma_cnt; rb = rx_log.size();
    spi_frame(1'b0, 1'b0, 1'b1, 2, 0, 4);
    chk("ovf_rx_veri", 32'(rx_veri_o), 32'h11);
    chk("ovf_rx_gecerli", 32'(rx_gecerli_o), 32'd1);
    chk("ovf_tasma", 32'(tasma_cnt - t0), 32'd1);
    rx_hazir_i = 1'b1;
    tick(2);
    chk("ovf_accept_clears", 32'(rx_gecerli_o), 32'd0);
    chk("ovf_accepted_byte", (rx_log.size() == rb + 1) ? 32'(rx_log[rb]) : 32'hxxxx_xxxx, 32'h11);

    // Abort after 5 bits, then a clean frame.
    rb = rx_log.size();
    m_tx[0] = 8'($urandom);
    spi_frame(1'b0, 1'b0, 1'b1, 1, 5, 4);
    chk("abort_no_rx", 32'(rx_log.size() - rb), 32'd0);
    chk("abort_no_valid", 32'(rx_gecerli_o), 32'd0);
    m_tx[0] = 8'h5A;
    f_tx[0] = 8'h3E; f_tx[1] = 8'h00;
    checked_frame(1'b0, 1'b0, 1'b1, 1, 2, "after_abort");

    // Randomised frames across modes, lengths and TX supply.
    for (int r = 0; r < 6; r++) begin
      cp = 1'($urandom_range(1, 0));
      ch = 1'($urandom_range(1, 0));
      mb = 1'($urandom_range(1, 0));
      n = $urandom_range(3, 1);
      loads = ch ? n : n + 1;
      nfed = $urandom_range(loads, 0);
      for (int k = 0; k < 8; k++) begin
        m_tx[k] = 8'($urandom);
        f_tx[k] = 8'($urandom);
      end
      checked_frame(cp, ch, mb, n, nfed, $sformatf("rnd%0d", r));
    end

    // Reset mid-byte at f_sck = f_clk/8.
    f_tx[0] = 8'h96;
    push_feed(1);
    cfg_cpol_i = 1'b0; cfg_cpha_i = 1'b0; cfg_msb_first_i = 1'b1;
    sck_i = 1'b0;
    tick(4);
    csn_i = 1'b0; mosi_i = 1'b1;
    tick(4);
    for (int i = 0; i < 3; i++) begin
      sck_i = 1'b1; tick(4);
      sck_i = 1'b0; tick(4);
    end
    sck_i = 1'b1;
    tick(2);
    chk("pre_rst_aktif", 32'(aktif_o), 32'd1);
    rstn_i = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("inrst_miso", 32'(miso_o), 32'd0);
      chk("inrst_oe_aktif", {30'd0, miso_oe_o, aktif_o}, 32'd0);
      chk("inrst_rx", {23'd0, rx_gecerli_o, rx_veri_o}, 32'd0);
      chk("inrst_pulses", {30'd0, rx_tasma_o, tx_eksik_o}, 32'd0);
      chk("inrst_tx_hazir", 32'(tx_hazir_o), 32'd1);
      tick(2);
    end
    csn_i = 1'b1; sck_i = 1'b0;
    tick(2);
    rstn_i = 1'b1;
    tick(4);
    chk("post_rst_idle", 32'(aktif_o), 32'd0);
    m_tx[0] = 8'($urandom);
    f_tx[0] = 8'hC3; f_tx[1] = 8'h00;
    checked_frame(1'b0, 1'b0, 1'b1, 1, 2, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
